// File: rtl/instr_prefetch_if.sv
// Core-fetch and controller-instruction-port bundle for instr_prefetch.
// master = prefetch buffer, slave = core + memory controller side.
interface instr_prefetch_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          core_req;
  logic [31:0]   core_pc;
  logic [31:0]   core_instr;
  logic          core_valid;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_data;
  logic          fetch_ready;
  logic [CW-1:0] pf_count;

  modport master (
    input  core_req, core_pc, fetch_data, fetch_ready,
    output core_instr, core_valid, fetch_addr, pf_count
  );

  modport slave (
    output core_req, core_pc, fetch_data, fetch_ready,
    input  core_instr, core_valid, fetch_addr, pf_count
  );
endinterface

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetch FIFO: hit served 1 cycle later, one hit per 2 cycles.
// Full FIFO drops fetch pulses without advancing fetch_addr, so the word is refetched.
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  instr_prefetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   head_pc_q, head_pc_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          discard_q, discard_d;
  logic          lock_q, lock_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [31:0]   core_instr_q, core_instr_d;
  logic          core_valid_q, core_valid_d;

  logic req_ok, pc_match, redirect, hit, push;

  always_comb begin
    req_ok   = bus.core_req && !lock_q;
    pc_match = (bus.core_pc == head_pc_q);
    redirect = req_ok && !pc_match;
    hit      = req_ok && pc_match && (count_q != '0);
    // A pop frees the slot being written, so a full FIFO still accepts on a hit.
    push     = bus.fetch_ready && !discard_q && !redirect && ((count_q < FULL) || hit);

    head_pc_d    = head_pc_q;
    fetch_addr_d = fetch_addr_q;
    count_d      = count_q;
    discard_d    = discard_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    mem_d        = mem_q;

    if (redirect) begin
      head_pc_d    = bus.core_pc;
      fetch_addr_d = bus.core_pc;
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      // A coincident pulse is for the old address; the next fetch already samples the new one.
      discard_d    = !bus.fetch_ready;
    end else begin
      if (bus.fetch_ready && discard_q) begin
        discard_d = 1'b0;
      end
      if (push) begin
        mem_d[wr_ptr_q] = bus.fetch_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        fetch_addr_d    = fetch_addr_q + 32'd4;
      end
      if (hit) begin
        head_pc_d = head_pc_q + 32'd4;
        rd_ptr_d  = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(hit);
    end

    lock_d       = hit;
    core_valid_d = hit;
    core_instr_d = hit ? mem_q[rd_ptr_q] : core_instr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_pc_q    <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      count_q      <= '0;
      discard_q    <= 1'b0;
      lock_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      core_instr_q <= '0;
      core_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_pc_q    <= head_pc_d;
      fetch_addr_q <= fetch_addr_d;
      count_q      <= count_d;
      discard_q    <= discard_d;
      lock_q       <= lock_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      core_instr_q <= core_instr_d;
      core_valid_q <= core_valid_d;
      mem_q        <= mem_d;
    end
  end

  assign bus.core_instr = core_instr_q;
  assign bus.core_valid = core_valid_q;
  assign bus.fetch_addr = fetch_addr_q;
  assign bus.pf_count   = count_q;
endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch at DEPTH=4: fill, full drop, pop+push, redirects, reset, wrap.
module tb_instr_prefetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;

  instr_prefetch_if #(.DEPTH(DEPTH)) bus ();

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch_ready pulse, then one idle cycle.
  task automatic pulse_gap(input logic [31:0] data);
    bus.fetch_ready = 1'b1;
    bus.fetch_data  = data;
    step();
    bus.fetch_ready = 1'b0;
    step();
  endtask

  logic [31:0] fill_w [4];

  initial begin
    fill_w[0] = 32'h0000_0013;
    fill_w[1] = 32'h0010_0093;
    fill_w[2] = 32'h0020_0113;
    fill_w[3] = 32'h0030_0193;

    rst             = 1'b1;
    bus.core_req    = 1'b0;
    bus.core_pc     = RPC;
    bus.fetch_ready = 1'b0;
    bus.fetch_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.core_valid), 32'd0);
    chk("rst_instr", bus.core_instr, 32'd0);
    chk("rst_count", 32'(bus.pf_count), 32'd0);
    chk("rst_faddr", bus.fetch_addr, RPC);
    rst = 1'b0;
    step();

    // Sequential fill with the core idle
    for (int i = 0; i < 4; i++) pulse_gap(fill_w[i]);
    chk("fill_faddr", bus.fetch_addr, 32'h8000_0010);
    chk("fill_count", 32'(bus.pf_count), 32'd4);
    chk("fill_valid", 32'(bus.core_valid), 32'd0);

    // Pulses on a full FIFO are dropped
    for (int i = 0; i < 3; i++) pulse_gap(32'hFFFF_FFFF);
    chk("drop_faddr", bus.fetch_addr, 32'h8000_0010);
    chk("drop_count", 32'(bus.pf_count), 32'd4);

    // Hit and push in the same cycle while full
    bus.core_req    = 1'b1;
    bus.core_pc     = RPC;
    bus.fetch_ready = 1'b1;
    bus.fetch_data  = 32'h0040_0213;
    step();
    bus.fetch_ready = 1'b0;
    bus.core_pc     = RPC + 32'd4;
    chk("pp_valid", 32'(bus.core_valid), 32'd1);
    chk("pp_instr", bus.core_instr, 32'h0000_0013);
    chk("pp_count", 32'(bus.pf_count), 32'd4);
    chk("pp_faddr", bus.fetch_addr, 32'h8000_0014);
    step();
    chk("lock_valid", 32'(bus.core_valid), 32'd0);
    chk("lock_count", 32'(bus.pf_count), 32'd4);
    step();
    chk("b2b_valid", 32'(bus.core_valid), 32'd1);
    chk("b2b_instr", bus.core_instr, 32'h0010_0093);
    chk("b2b_count", 32'(bus.pf_count), 32'd3);

    // Branch redirect with discard of the next pulse
    bus.core_pc = 32'h8000_0100;
    step();
    step();
    chk("br_count", 32'(bus.pf_count), 32'd0);
    chk("br_faddr", bus.fetch_addr, 32'h8000_0100);
    chk("br_valid", 32'(bus.core_valid), 32'd0);
    bus.fetch_ready = 1'b1;
    bus.fetch_data  = 32'hBAD0_BAD0;
    step();
    bus.fetch_ready = 1'b0;
    chk("disc_count", 32'(bus.pf_count), 32'd0);
    chk("disc_faddr", bus.fetch_addr, 32'h8000_0100);
    bus.fetch_ready = 1'b1;
    bus.fetch_data  = 32'h1110_0113;
    step();
    bus.fetch_ready = 1'b0;
    chk("cold_count", 32'(bus.pf_count), 32'd1);
    chk("cold_faddr", bus.fetch_addr, 32'h8000_0104);
    chk("cold_valid_t1", 32'(bus.core_valid), 32'd0);
    step();
    chk("cold_valid_t2", 32'(bus.core_valid), 32'd1);
    chk("cold_instr", bus.core_instr, 32'h1110_0113);

    // Redirect coincident with a pulse: no discard afterwards
    bus.core_pc = 32'h8000_0200;
    step();
    bus.fetch_ready = 1'b1;
    bus.fetch_data  = 32'hDEAD_0000;
    step();
    bus.fetch_data  = 32'h2220_0113;
    chk("co_count", 32'(bus.pf_count), 32'd0);
    chk("co_faddr", bus.fetch_addr, 32'h8000_0200);
    step();
    bus.fetch_ready = 1'b0;
    chk("co_push_count", 32'(bus.pf_count), 32'd1);
    chk("co_push_faddr", bus.fetch_addr, 32'h8000_0204);
    step();
    chk("co_valid", 32'(bus.core_valid), 32'd1);
    chk("co_instr", bus.core_instr, 32'h2220_0113);

    // Mid-operation reset with count=2 and core_valid high
    bus.core_req = 1'b0;
    pulse_gap(32'h3330_0193);
    pulse_gap(32'h3340_0193);
    pulse_gap(32'h3350_0193);
    chk("pre_rst_count3", 32'(bus.pf_count), 32'd3);
    bus.core_req = 1'b1;
    bus.core_pc  = 32'h8000_0204;
    step();
    chk("pre_rst_count", 32'(bus.pf_count), 32'd2);
    chk("pre_rst_valid", 32'(bus.core_valid), 32'd1);
    chk("pre_rst_instr", bus.core_instr, 32'h3330_0193);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.core_valid), 32'd0);
    chk("mid_rst_count", 32'(bus.pf_count), 32'd0);
    chk("mid_rst_faddr", bus.fetch_addr, RPC);
    chk("mid_rst_instr", bus.core_instr, 32'd0);
    bus.core_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // In-flight pulse after reset lands as data for RESET_PC
    bus.fetch_ready = 1'b1;
    bus.fetch_data  = 32'h0000_0013;
    step();
    bus.fetch_ready = 1'b0;
    chk("post_rst_count", 32'(bus.pf_count), 32'd1);
    chk("post_rst_faddr", bus.fetch_addr, RPC + 32'd4);

    // Address wrap from 0xFFFFFFFC to 0
    bus.core_req = 1'b1;
    bus.core_pc  = 32'hFFFF_FFFC;
    step();
    chk("wrap_redir_count", 32'(bus.pf_count), 32'd0);
    chk("wrap_redir_faddr", bus.fetch_addr, 32'hFFFF_FFFC);
    pulse_gap(32'h1234_5678);
    chk("wrap_disc_count", 32'(bus.pf_count), 32'd0);
    bus.fetch_ready = 1'b1;
    bus.fetch_data  = 32'hCAFE_0013;
    step();
    bus.fetch_ready = 1'b0;
    chk("wrap_faddr", bus.fetch_addr, 32'h0000_0000);
    chk("wrap_count", 32'(bus.pf_count), 32'd1);
    step();
    chk("wrap_valid", 32'(bus.core_valid), 32'd1);
    chk("wrap_instr", bus.core_instr, 32'hCAFE_0013);
    bus.core_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
